// File: rtl/gearbox_66to64_tx.sv
// rtl/gearbox_66to64_tx.sv - 66b block to 64b word TX gearbox, one drain cycle per 33.
// Optional sync-header check enabled by defining TXGB_HDR_CHECK_EN.
module gearbox_66to64_tx #(
    parameter int REVERSE = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  sync_hdr,
    input  logic [63:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        hdr_err
);

    logic [5:0]   seq;
    logic [63:0]  residual;
    logic         drain;
    logic         xfer;
    logic [6:0]   r;
    logic [127:0] stream;

    function automatic logic [63:0] order(input logic [63:0] w);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) begin
            m[i] = w[63-i];
        end
        return (REVERSE != 0) ? m : w;
    endfunction

    assign drain    = (seq == 6'd32);
    assign in_ready = RST_N && !drain;
    assign xfer     = in_valid && in_ready;
    assign r        = {seq, 1'b0};

    // Residual bits above r are always zero, so OR-ing in the shifted block is exact.
    // r <= 62 on a transfer, so the shifted 66-bit block never exceeds bit 127.
    always_comb begin
        stream = ({62'b0, data_in, sync_hdr} << r) | {64'b0, residual};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seq       <= 6'd0;
            residual  <= 64'h0;
            out_data  <= 64'h0;
            out_valid <= 1'b0;
        end else if (drain) begin
            out_data  <= order(residual);
            out_valid <= 1'b1;
            seq       <= 6'd0;
            residual  <= 64'h0;
        end else if (xfer) begin
            out_data  <= order(stream[63:0]);
            out_valid <= 1'b1;
            residual  <= stream[127:64];
            seq       <= seq + 6'd1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef TXGB_HDR_CHECK_EN
    // 2'b00 and 2'b11 are not legal sync headers; the block is still packed as-is.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hdr_err <= 1'b0;
        end else if (xfer && (sync_hdr[0] == sync_hdr[1])) begin
            hdr_err <= 1'b1;
        end
    end
`else
    assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_66to64_tx.sv
// tb/tb_gearbox_66to64_tx.sv - scoreboard bench for gearbox_66to64_tx against a bitstream model.
module tb_gearbox_66to64_tx;

    localparam int REV = 0;
`ifdef TXGB_HDR_CHECK_EN
    localparam bit HDR_CHK = 1'b1;
`else
    localparam bit HDR_CHK = 1'b0;
`endif

    logic        CLK;
    logic        RST_N;
    logic [1:0]  sync_hdr;
    logic [63:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        hdr_err;

    gearbox_66to64_tx #(.REVERSE(REV)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .sync_hdr (sync_hdr),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .hdr_err  (hdr_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    bit          bq[$];
    bit          expq[$];
    bit          sb_active   = 1'b0;
    bit          hdr_err_exp = 1'b0;
    int          frame_cnt   = 0;
    int          xfer_cnt    = 0;
    logic [63:0] last_out    = 64'h0;

    function automatic logic [63:0] mirror(input logic [63:0] w);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = w[63-i];
        return m;
    endfunction

    function automatic logic [63:0] ordered(input logic [63:0] w);
        return (REV != 0) ? mirror(w) : w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the serial stream is the concatenation of all accepted blocks;
    // every valid output word is simply the next 64 bits of it.
    always @(posedge CLK) begin
        #1;
        if (!RST_N) begin
            last_out = 64'h0;
        end else if (sb_active) begin
            if (expq.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                bit          ev;
                logic [63:0] w;
                ev = expq.pop_front();
                chk("out_valid", {63'b0, out_valid}, {63'b0, ev});
                if (ev) begin
                    if (bq.size() < 64) begin
                        chk("bitstream_short", 64'(bq.size()), 64'd64);
                    end else begin
                        for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
                        chk("out_data", out_data, ordered(w));
                    end
                end else begin
                    chk("out_hold", out_data, last_out);
                end
                last_out = out_data;
                chk("hdr_err", {63'b0, hdr_err}, {63'b0, hdr_err_exp});
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST_N     = 1'b0;
        in_valid  = 1'b1;
        sb_active = 1'b0;
        expq.delete();
        bq.delete();
        frame_cnt   = 0;
        hdr_err_exp = 1'b0;
        #1;
        chk("rst_async_data", out_data, 64'h0);
        chk("rst_async_valid", {63'b0, out_valid}, 64'd0);
        repeat (n) begin
            @(negedge CLK);
            chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
            chk("rst_out_data", out_data, 64'h0);
            chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
            chk("rst_hdr_err", {63'b0, hdr_err}, 64'd0);
        end
        RST_N    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {63'b0, in_ready}, 64'd1);
        expq.push_back(1'b0);
        sb_active = 1'b1;
    endtask

    task automatic cycle(input bit v, input logic [1:0] h, input logic [63:0] d,
                         output bit taken, output bit rdy);
        @(negedge CLK);
        rdy = in_ready;
        chk("in_ready", {63'b0, in_ready}, {63'b0, frame_cnt != 32});
        in_valid = v;
        sync_hdr = h;
        data_in  = d;
        taken    = 1'b0;
        if (frame_cnt == 32) begin
            frame_cnt = 0;
            expq.push_back(1'b1);
        end else if (v) begin
            for (int i = 0; i < 2; i++)  bq.push_back(h[i]);
            for (int i = 0; i < 64; i++) bq.push_back(d[i]);
            frame_cnt++;
            xfer_cnt++;
            taken = 1'b1;
            expq.push_back(1'b1);
            if (h[0] == h[1] && HDR_CHK) hdr_err_exp = 1'b1;
        end else begin
            expq.push_back(1'b0);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [1:0] rnd_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        bit          tk;
        bit          rd;
        int          lows[$];
        logic [1:0]  h;
        logic [63:0] d;
        int          blocks;

        RST_N    = 1'b0;
        in_valid = 1'b1;
        sync_hdr = 2'b00;
        data_in  = 64'h0;

        // Reset, then the two directed blocks
        do_reset(3);
        cycle(1'b1, 2'b01, 64'h0, tk, rd);
        cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, tk, rd);
        chk("first_word", out_data, ordered(64'h0000_0000_0000_0001));
        cycle(1'b0, 2'b01, 64'h0, tk, rd);
        chk("second_word", out_data, ordered(64'hFFFF_FFFF_FFFF_FFF8));

        // Sustained in_valid for 99 cycles
        do_reset(1);
        xfer_cnt = 0;
        h = rnd_hdr();
        d = rnd64();
        for (int c = 1; c <= 99; c++) begin
            cycle(1'b1, h, d, tk, rd);
            if (!rd) lows.push_back(c);
            if (tk) begin
                h = rnd_hdr();
                d = rnd64();
            end
        end
        chk("sustained_xfers", 64'(xfer_cnt), 64'd96);
        chk("ready_low_count", 64'(lows.size()), 64'd3);
        for (int i = 0; i < lows.size() && i < 3; i++)
            chk("ready_low_cycle", 64'(lows[i]), 64'(33 * (i + 1)));

        // Random gaps over 200 blocks
        blocks = 0;
        h = rnd_hdr();
        d = rnd64();
        for (int c = 0; c < 2000 && blocks < 200; c++) begin
            cycle($urandom_range(0, 1) != 0, h, d, tk, rd);
            if (tk) begin
                blocks++;
                h = rnd_hdr();
                d = rnd64();
            end
        end
        chk("random_blocks", 64'(blocks), 64'd200);

        // Reset mid-frame at seq 17
        for (int c = 0; c < 40 && frame_cnt != 17; c++)
            cycle(1'b1, rnd_hdr(), rnd64(), tk, rd);
        chk("reached_seq17", 64'(frame_cnt), 64'd17);
        do_reset(2);
        cycle(1'b1, 2'b01, 64'h0, tk, rd);
        cycle(1'b0, 2'b01, 64'h0, tk, rd);
        chk("post_reset_word", out_data,
            (REV != 0) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_0000_0001);

        // Illegal header at seq 5
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, rnd64(), tk, rd);
        cycle(1'b1, 2'b11, rnd64(), tk, rd);
        cycle(1'b0, 2'b01, 64'h0, tk, rd);
        chk("hdr_err_set", {63'b0, hdr_err}, {63'b0, HDR_CHK});
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'b10, rnd64(), tk, rd);
        chk("hdr_err_sticky", {63'b0, hdr_err}, {63'b0, HDR_CHK});
        do_reset(1);
        cycle(1'b0, 2'b01, 64'h0, tk, rd);
        cycle(1'b0, 2'b01, 64'h0, tk, rd);
        @(posedge CLK);
        #2;
        chk("sb_empty", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
